// File: rtl/button_deb_multi_if.sv
// Button bundle between the board pads and user logic, one bit per channel.
// Latency: none, wires only.
// Backpressure: none; the button side is free-running and every strobe is a single-cycle pulse.
//
// Signals (NCHAN bits each):
//   button_in  raw button pads, 1 = pressed
//   level_o    debounced level
//   press_o    1-cycle strobe on a debounced 0->1
//   release_o  1-cycle strobe on a debounced 1->0
//   toggle_o   flips on every press
//   long_o     1-cycle long-press strobe
// Modports: master = pad/user side, slave = debouncer.
interface button_deb_multi_if #(
  parameter int NCHAN = 4
);
  logic [NCHAN-1:0] button_in;
  logic [NCHAN-1:0] level_o;
  logic [NCHAN-1:0] press_o;
  logic [NCHAN-1:0] release_o;
  logic [NCHAN-1:0] toggle_o;
  logic [NCHAN-1:0] long_o;

  modport master (
    output button_in,
    input  level_o, press_o, release_o, toggle_o, long_o
  );

  modport slave (
    input  button_in,
    output level_o, press_o, release_o, toggle_o, long_o
  );
endinterface

// File: rtl/button_deb_multi.sv
// Debounces NCHAN push-buttons on a shared 1 ms tick, giving level, press/release strobes, toggle and long-press.
// Latency: 2-cycle synchroniser, then DEBOUNCE_MS-1..DEBOUNCE_MS ms of stable input before level_o moves.
// Backpressure: none; strobes are single-cycle pulses and must be sampled every cycle.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   btn  button_deb_multi_if.slave (button_in in; level_o, press_o, release_o, toggle_o, long_o out)
// Optional feature: define BUTTON_DEB_LONG_PRESS_EN to build the per-channel hold counters that drive
// long_o; without it long_o is tied to 0 and LONG_MS only takes part in the parameter sanity check.
module button_deb_multi #(
  parameter int NCHAN        = 4,
  parameter int CLK_FREQ_KHZ = 95000,
  parameter int DEBOUNCE_MS  = 20,
  parameter int LONG_MS      = 1000
) (
  input  logic              clk,
  input  logic              rst,
  button_deb_multi_if.slave btn
);

  localparam int PW = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  if (NCHAN < 1 || DEBOUNCE_MS < 1 || CLK_FREQ_KHZ < 1 || LONG_MS <= DEBOUNCE_MS) begin : g_bad_params
    $error("button_deb_multi: illegal parameter combination");
  end

  // Synchroniser, prescaler and per-channel state
  logic [NCHAN-1:0] sync_q1;
  logic [NCHAN-1:0] sync;
  logic [PW-1:0]    presc;
  logic             tick;

  logic [CW-1:0]    cnt_q [NCHAN];
  logic [CW-1:0]    cnt_d [NCHAN];
  logic [NCHAN-1:0] flip;

  logic [NCHAN-1:0] level_q, level_d;
  logic [NCHAN-1:0] press_q, press_d;
  logic [NCHAN-1:0] rel_q,   rel_d;
  logic [NCHAN-1:0] tog_q,   tog_d;

  assign tick = (presc == PW'(CLK_FREQ_KHZ - 1));

  // Debounce: any cycle in which the synchronised input agrees with the
  // current level restarts the window, so only an uninterrupted run of
  // DEBOUNCE_MS ticks of disagreement moves the level. The counter is
  // cleared on the flip itself, which is why it can never wrap.
  always_comb begin
    flip = '0;
    for (int i = 0; i < NCHAN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CW'(DEBOUNCE_MS - 1)) begin
          cnt_d[i] = '0;
          flip[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    level_d = level_q ^ flip;
    // Strobes are registered alongside the level so they line up with the
    // first cycle the new level is visible.
    press_d = flip & sync;
    rel_d   = flip & ~sync;
    tog_d   = tog_q ^ press_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync    <= '0;
      presc   <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      tog_q   <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q1 <= btn.button_in;
      sync    <= sync_q1;
      presc   <= tick ? '0 : presc + PW'(1);
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      tog_q   <= tog_d;
      for (int i = 0; i < NCHAN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn.level_o   = level_q;
  assign btn.press_o   = press_q;
  assign btn.release_o = rel_q;
  assign btn.toggle_o  = tog_q;

`ifdef BUTTON_DEB_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_MS + 1);

  logic [HW-1:0]    hold_q [NCHAN];
  logic [HW-1:0]    hold_d [NCHAN];
  logic [NCHAN-1:0] long_q, long_d;

  // Hold counter runs on ticks while the debounced level is high and parks
  // at LONG_MS, so the long strobe fires once per press.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < NCHAN; i++) begin
      hold_d[i] = hold_q[i];
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && (hold_q[i] != HW'(LONG_MS))) begin
        hold_d[i] = hold_q[i] + HW'(1);
        if (hold_q[i] == HW'(LONG_MS - 1)) begin
          long_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_q <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      long_q <= long_d;
      for (int i = 0; i < NCHAN; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign btn.long_o = long_q;
`else
  assign btn.long_o = '0;
`endif

endmodule
